// File: rtl/nanoz80_pkg.sv
// Shared definitions for the nanoz80 interrupt controller: register map and FSM state type.
package nanoz80_pkg;

  localparam int unsigned NUM_IRQ = 4;

  localparam logic [1:0] INT_ENABLE  = 2'd0;
  localparam logic [1:0] INT_PENDING = 2'd1;
  localparam logic [1:0] INT_VBASE   = 2'd2;
  localparam logic [1:0] INT_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StAck,
    StService
  } int_state_t;

endpackage

// File: rtl/int_prio_enc.sv
// Combinational fixed-priority encoder; bit 0 has the highest priority.
module int_prio_enc #(
  parameter int unsigned NumReq = 4
) (
  input  logic [NumReq-1:0] req_i,
  output logic [1:0]        idx_o,
  output logic              valid_o
);

  always_comb begin
    idx_o   = 2'd0;
    valid_o = 1'b0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = 2'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Z80-style vectored interrupt controller: edge-latched pending bits, enable mask,
// priority select and an IDLE/REQ/ACK/SERVICE handshake with the CPU INTA cycle.
module int_ctrl #(
  parameter int unsigned NUM_IRQ = nanoz80_pkg::NUM_IRQ
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               m1_n,
  input  logic               ioreq_n,
  input  logic               wr_n,
  input  logic [1:0]         reg_addr_i,
  input  logic [7:0]         data_i,
  input  logic               int_cs,
  output logic [7:0]         data_o,
  output logic               ack_o,
  output logic               int_n
);

  import nanoz80_pkg::*;

  int_state_t         state_q, state_d;
  logic [NUM_IRQ-1:0] irq_q, enable_q, enable_d, pending_q, pending_d;
  logic [NUM_IRQ-1:0] rise, masked, w1c_mask, take_mask;
  logic [4:0]         vbase_q, vbase_d;
  logic [1:0]         src_q, src_d, prio_idx;
  logic               prio_valid, arm_q, inta, inta_q, inta_first;
  logic               wr_en, eoi, take, int_n_q, int_n_d, in_service;

  assign inta       = ~m1_n & ~ioreq_n;
  assign inta_first = inta & ~inta_q;
  assign wr_en      = int_cs & ~wr_n;
  assign eoi        = wr_en && (reg_addr_i == INT_STATUS);
  // arm_q masks the first cycle after reset so a level already high is not seen as an edge.
  assign rise       = irq_i & ~irq_q & {NUM_IRQ{arm_q}};
  assign masked     = pending_q & enable_q;
  assign in_service = (state_q == StService);
  assign ack_o      = (state_q == StAck) && inta;
  assign int_n      = int_n_q;

  int_prio_enc #(
    .NumReq (NUM_IRQ)
  ) u_prio_enc (
    .req_i   (masked),
    .idx_o   (prio_idx),
    .valid_o (prio_valid)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    take    = 1'b0;
    case (state_q)
      StIdle:    if (|masked) state_d = StReq;
      StReq: begin
        if (!prio_valid) begin
          state_d = StIdle;
        end else if (inta_first) begin
          state_d = StAck;
          src_d   = prio_idx;
          take    = 1'b1;
        end
      end
      StAck:     if (ioreq_n) state_d = StService;
      StService: if (eoi) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    int_n_d = (state_d != StReq);
  end

  always_comb begin
    enable_d = enable_q;
    vbase_d  = vbase_q;
    w1c_mask = '0;
    if (wr_en && (reg_addr_i == INT_ENABLE)) enable_d = data_i[NUM_IRQ-1:0];
    if (wr_en && (reg_addr_i == INT_VBASE))  vbase_d = data_i[7:3];
    if (wr_en && (reg_addr_i == INT_PENDING)) w1c_mask = data_i[NUM_IRQ-1:0];
    for (int i = 0; i < NUM_IRQ; i++) begin
      take_mask[i] = take && (prio_idx == 2'(i));
    end
    // New edges take precedence over any clear in the same cycle.
    pending_d = (pending_q & ~(w1c_mask | take_mask)) | rise;
  end

  always_comb begin
    data_o = 8'h00;
    if (ack_o) begin
      data_o = {vbase_q, src_q, 1'b0};
    end else begin
      case (reg_addr_i)
        INT_ENABLE:  data_o[NUM_IRQ-1:0] = enable_q;
        INT_PENDING: data_o[NUM_IRQ-1:0] = pending_q;
        INT_VBASE:   data_o = {vbase_q, 3'b000};
        default:     data_o = {in_service, 5'b00000, src_q};
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      irq_q     <= '0;
      enable_q  <= '0;
      pending_q <= '0;
      vbase_q   <= 5'd0;
      src_q     <= 2'd0;
      arm_q     <= 1'b0;
      inta_q    <= 1'b0;
      int_n_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_i;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      vbase_q   <= vbase_d;
      src_q     <= src_d;
      arm_q     <= 1'b1;
      inta_q    <= inta;
      int_n_q   <= int_n_d;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: expected reads and vectors go through a scoreboard queue.
module tb_int_ctrl;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] irq = '0;
  logic         m1_n = 1'b1;
  logic         ioreq_n = 1'b1;
  logic         wr_n = 1'b1;
  logic         int_cs = 1'b0;
  logic [1:0]   addr = 2'd0;
  logic [7:0]   wdata = 8'h00;
  logic [7:0]   data_o;
  logic         ack;
  logic         int_n;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  int_ctrl #(
    .NUM_IRQ (N)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .irq_i      (irq),
    .m1_n       (m1_n),
    .ioreq_n    (ioreq_n),
    .wr_n       (wr_n),
    .reg_addr_i (addr),
    .data_i     (wdata),
    .int_cs     (int_cs),
    .data_o     (data_o),
    .ack_o      (ack),
    .int_n      (int_n)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input logic [7:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 8'(sb.size()), 8'd1);
    end else begin
      e = sb.pop_front();
      check_eq(e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
    sb_push(tag, exp);
    addr = a;
    #1;
    sb_pop(data_o);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    addr   = a;
    wdata  = d;
    int_cs = 1'b1;
    wr_n   = 1'b0;
    tick();
    int_cs = 1'b0;
    wr_n   = 1'b1;
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    check_eq(tag, {7'b0, obs}, {7'b0, exp});
  endtask

  task automatic wait_int(input string tag, input logic lvl);
    for (int i = 0; i < 8 && int_n !== lvl; i++) tick();
    chk_bit(tag, int_n, lvl);
  endtask

  task automatic inta_cycle(input string tag, input logic [7:0] vec);
    sb_push({tag, "_vec"}, vec);
    m1_n    = 1'b0;
    ioreq_n = 1'b0;
    tick();
    chk_bit({tag, "_ack"}, ack, 1'b1);
    sb_pop(data_o);
    chk_bit({tag, "_intn_hi"}, int_n, 1'b1);
    m1_n    = 1'b1;
    ioreq_n = 1'b1;
    tick();
    chk_bit({tag, "_ack_lo"}, ack, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_bit("rst_intn", int_n, 1'b1);
    chk_bit("rst_ack", ack, 1'b0);
    rd("rst_enable", 2'd0, 8'h00);
    rd("rst_status", 2'd3, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Scenario 1: single source, full handshake.
    wr(2'd0, 8'h02);
    wr(2'd2, 8'h47);
    rd("s1_enable", 2'd0, 8'h02);
    rd("s1_vbase", 2'd2, 8'h40);
    irq = 4'b0010;
    tick();
    chk_bit("s1_intn_pre", int_n, 1'b1);
    irq = '0;
    tick();
    chk_bit("s1_intn_low", int_n, 1'b0);
    inta_cycle("s1", 8'h42);
    rd("s1_status", 2'd3, 8'h81);
    rd("s1_pend", 2'd1, 8'h00);
    wr(2'd3, 8'h00);
    rd("s1_status_eoi", 2'd3, 8'h01);
    chk_bit("s1_idle_intn", int_n, 1'b1);

    // Scenario 2: simultaneous edges, priority order.
    wr(2'd0, 8'h0F);
    irq = 4'b1001;
    tick();
    irq = '0;
    wait_int("s2_int1", 1'b0);
    inta_cycle("s2_src0", 8'h40);
    rd("s2_pend", 2'd1, 8'h08);
    chk_bit("s2_svc_intn", int_n, 1'b1);
    wr(2'd3, 8'h00);
    wait_int("s2_int2", 1'b0);
    inta_cycle("s2_src3", 8'h46);
    wr(2'd3, 8'h00);
    rd("s2_pend_end", 2'd1, 8'h00);

    // Scenario 3: request withdrawn by disabling; spurious INTA in IDLE.
    wr(2'd0, 8'h04);
    irq = 4'b0100;
    tick();
    irq = '0;
    wait_int("s3_int", 1'b0);
    wr(2'd0, 8'h00);
    tick();
    chk_bit("s3_intn_hi", int_n, 1'b1);
    rd("s3_status", 2'd3, 8'h03);
    rd("s3_pend", 2'd1, 8'h04);
    m1_n    = 1'b0;
    ioreq_n = 1'b0;
    #1;
    chk_bit("s3_spur_ack0", ack, 1'b0);
    tick();
    chk_bit("s3_spur_ack1", ack, 1'b0);
    rd("s3_spur_status", 2'd3, 8'h03);
    m1_n    = 1'b1;
    ioreq_n = 1'b1;
    wr(2'd1, 8'h04);
    rd("s3_pend_clr", 2'd1, 8'h00);

    // Scenario 4: set beats W1C in the same cycle.
    irq    = 4'b0001;
    addr   = 2'd1;
    wdata  = 8'h01;
    int_cs = 1'b1;
    wr_n   = 1'b0;
    tick();
    int_cs = 1'b0;
    wr_n   = 1'b1;
    rd("s4_set_wins", 2'd1, 8'h01);
    wr(2'd1, 8'h01);
    rd("s4_w1c", 2'd1, 8'h00);
    irq = '0;
    tick();

    // Scenario 5: reset during ACK, held source after release.
    wr(2'd0, 8'h01);
    wr(2'd2, 8'h80);
    irq = 4'b0001;
    wait_int("s5_int", 1'b0);
    sb_push("s5_vec", 8'h80);
    m1_n    = 1'b0;
    ioreq_n = 1'b0;
    tick();
    chk_bit("s5_ack", ack, 1'b1);
    sb_pop(data_o);
    #2;
    rst_n = 1'b0;
    #1;
    chk_bit("s5_rst_intn", int_n, 1'b1);
    chk_bit("s5_rst_ack", ack, 1'b0);
    rd("s5_rst_en", 2'd0, 8'h00);
    rd("s5_rst_pend", 2'd1, 8'h00);
    rd("s5_rst_vb", 2'd2, 8'h00);
    rd("s5_rst_st", 2'd3, 8'h00);
    m1_n    = 1'b1;
    ioreq_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wr(2'd0, 8'h01);
    repeat (4) tick();
    chk_bit("s5_held_intn", int_n, 1'b1);
    rd("s5_held_pend", 2'd1, 8'h00);
    irq = '0;
    tick();
    irq = 4'b0001;
    tick();
    irq = '0;
    wait_int("s5_new_edge", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter NUM_IRQ, default 4, number of interrupt sources; source 0 has the highest priority.
REQ-002 clk_i  input  1  system clock; CPU and all peripherals run on this one clock.
REQ-003 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 irq_i  input  NUM_IRQ  level-high requests from peripherals, synchronous to clk_i.
REQ-005 m1_n  input  1  CPU M1, active-low.
REQ-006 ioreq_n  input  1  CPU IORQ, active-low; m1_n=0 with ioreq_n=0 marks an INTA cycle.
REQ-007 wr_n  input  1  CPU write strobe, active-low.
REQ-008 reg_addr_i  input  2  register select.
REQ-009 data_i  input  8  CPU write data.
REQ-010 int_cs  input  1  chip select from the address decoder.
REQ-011 data_o  output  8  register read data, or the vector while ack_o=1.
REQ-012 ack_o  output  1  high while INTA is active in state ACK; selects data_o in the top-level CPU data mux.
REQ-013 int_n  output  1  registered Z80 INT request, active-low.

Function
REQ-014 Registers, offsets 0 to 3:
- 0 ENABLE[NUM_IRQ-1:0]: read/write.
- 1 PENDING: read; a write clears each pending bit where the written bit is 1 (write-1-to-clear).
- 2 VBASE[7:3]: read/write; reads return bits [2:0]=0.
- 3 STATUS/EOI: a read returns {in_service, 5'b0, src[1:0]}; a write of any value is EOI.
REQ-015 A register write occurs on every clock edge where int_cs=1 and wr_n=0; reads are combinational from reg_addr_i.
REQ-016 irq_i is registered into irq_q; pending[n] sets on the edge where irq_i[n]=1 and irq_q[n]=0, regardless of ENABLE.
REQ-017 When a set and a clear of the same pending bit occur in one cycle, whether the clear comes from a W1C write or from INTA, the set wins.
REQ-018 The state machine has four states: IDLE, REQ, ACK, SERVICE.
REQ-019 IDLE: if (pending & ENABLE) is nonzero, go to REQ.
REQ-020 REQ: int_n=0.
- If (pending & ENABLE) becomes 0, return to IDLE.
- On the first cycle of INTA, latch src (highest-priority set bit of pending & ENABLE), clear pending[src], and go to ACK.
REQ-021 ACK: int_n=1, ack_o=1 while INTA persists, data_o={VBASE[7:3], src[1:0], 1'b0}; go to SERVICE when ioreq_n=1.
REQ-022 SERVICE: int_n=1, in_service=1; new edges still set pending; an EOI write goes to IDLE. There is no nesting.
REQ-023 An EOI write in IDLE, REQ or ACK has no effect.
REQ-024 int_n is driven from a register: an edge sampled at clock edge N sets pending at N, the FSM reaches REQ at N+1, and int_n is low after N+1.
REQ-025 If INTA occurs while the FSM is in IDLE (a spurious INTA), the block ignores it: ack_o=0 and there is no state change.
REQ-026 src width is 2 bits; NUM_IRQ is limited to 4 or fewer.

Reset
REQ-027 rst_n_i=0 asynchronously forces: state=IDLE, int_n=1, ack_o=0, ENABLE=0, PENDING=0, VBASE=0, src=0, in_service=0, irq_q=0.
REQ-028 Reset asserted mid-INTA or in SERVICE aborts the interrupt with no residual pending bit.
REQ-029 After reset release, a source held high does not set pending until it shows a rising edge.

Structure
REQ-030 Shared package nanoz80_pkg holds: register offset constants (INT_ENABLE=0, INT_PENDING=1, INT_VBASE=2, INT_STATUS=3), the int_state_t enum, and NUM_IRQ.
REQ-031 The priority encoder is a single sub-module, int_prio_enc: NUM_IRQ-bit request in, 2-bit index plus valid out, combinational.

Verification
REQ-032 Scenario 1:
- Stimulus: ENABLE=0x2, VBASE=0x40, then a pulse on irq_i[1].
- Required: int_n low 2 cycles after the edge; INTA returns data_o=0x42 with ack_o=1; STATUS=0x81; EOI returns the FSM to IDLE.
REQ-033 Scenario 2:
- Stimulus: ENABLE=0xF, edges on sources 3 and 0 in the same cycle.
- Required: the first vector is VBASE|0x0; after EOI, int_n re-asserts and the vector is VBASE|0x6.
REQ-034 Scenario 3:
- Stimulus: source 2 pending while in REQ, then ENABLE written to 0.
- Required: int_n returns high and the FSM returns to IDLE; PENDING reads 0x4.
REQ-035 Scenario 4:
- Stimulus: W1C write of 0x1 to PENDING in the same cycle as a rising edge on irq_i[0].
- Required: pending[0] remains 1.
REQ-036 Scenario 5:
- Stimulus: rst_n_i pulsed low during ACK.
- Required: int_n=1, ack_o=0, all registers read 0 immediately; a source held high after reset does not interrupt.
